// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
package seg_pkg;

  // Slot phase: anodes dark during GUARD, selected digit may light during ON.
  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } slot_t;

  // Active-low segments, all dark.
  localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to active-low seven-segment pattern (bit 6 = a ... bit 0 = g).
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Full 16-entry table, 0-9 and A-F; no illegal codes.
  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'ha: seg = 7'b0001000;
      4'hb: seg = 7'b1100000;
      4'hc: seg = 7'b0110001;
      4'hd: seg = 7'b1000010;
      4'he: seg = 7'b0110000;
      4'hf: seg = 7'b0111000;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with a
// double-buffered load word swapped only at frame boundaries and a guard
// interval at the start of every digit slot.
// Optional feature: define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  slot_t                   state;
  logic [4*NUM_DIGITS-1:0] pend;
  logic [4*NUM_DIGITS-1:0] disp;
  logic                    pend_full;
  logic                    disp_valid;

  logic                    cnt_wrap;
  logic                    frame_end;
  logic                    accept;
  logic [3:0]              nib;
  logic [6:0]              dec;
  logic [NUM_DIGITS-1:0]   supp;
  logic [NUM_DIGITS-1:0]   an_nxt;

  // Handshake and wrap/boundary strobes.
  always_comb begin
    load_ready = ~pend_full;
    accept     = load_valid & ~pend_full;
    cnt_wrap   = (cnt == CNT_LAST);
    frame_end  = cnt_wrap && (idx == IDX_LAST);
    nib        = disp[{idx, 2'b00} +: 4];
  end

  seg_decoder u_dec (
    .hex (nib),
    .seg (dec)
  );

`ifdef SEG_SCAN_LZB_EN
  logic zero_run;

  // Suppress zero digits from the top down until the first non-zero one; digit 0 always lights.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS - 1; j++) begin
      zero_run = zero_run & (disp[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      supp[NUM_DIGITS-1-j] = zero_run;
    end
  end
`else
  // Every digit lights during ON.
  always_comb begin
    supp = '0;
  end
`endif

  // Anode pattern for the current slot, registered below.
  always_comb begin
    an_nxt = '1;
    if (state == ST_ON && disp_valid && !blank && !supp[idx])
      an_nxt[idx] = 1'b0;
  end

  // Counters, slot FSM, load buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      state      <= (GUARD == 0) ? ST_ON : ST_GUARD;
      pend       <= '0;
      pend_full  <= 1'b0;
      disp       <= '0;
      disp_valid <= 1'b0;
      seg        <= SEG_OFF;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      if (cnt_wrap) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        ST_GUARD: if (GUARD > 0 && cnt == GUARD_LAST) state <= ST_ON;
        ST_ON:    if (GUARD > 0 && cnt_wrap)          state <= ST_GUARD;
        default:  state <= ST_GUARD;
      endcase

      // Accept needs an empty pend, so it can never collide with the swap.
      if (frame_end && pend_full) begin
        disp       <= pend;
        disp_valid <= 1'b1;
        pend_full  <= 1'b0;
      end else if (accept) begin
        pend      <= load_data;
        pend_full <= 1'b1;
      end

      // Segments stay dark until a word has been displayed at least once.
      seg        <= disp_valid ? dec : SEG_OFF;
      an         <= an_nxt;
      frame_done <= (cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, PRESCALE=8, GUARD=2).
// Honours SEG_SCAN_LZB_EN when defined.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int PS = 8;
  localparam int GD = 2;
  localparam int FRAME = ND * PS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mt;
  logic [15:0] m_pend, m_disp;
  bit          m_pf, m_dv, acc;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_fd;

  logic [6:0] ref_seg [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  seg_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS), .GUARD(GD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank      (blank),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s t=%0t observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag, input bit ok);
    checks++;
    assert (ok)
    else begin
      errors++;
      $error("FAIL %s wait expired observed 0 expected 1", tag);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    int di, dc;
    logic [3:0] nb;
    bit sup;
    @(posedge clk);
    acc = 0;
    if (!rst_n) begin
      mt = 0; m_pend = '0; m_disp = '0; m_pf = 0; m_dv = 0;
      e_seg = 7'h7F; e_an = 4'hF; e_fd = 1'b0;
    end else begin
      di = mt / PS;
      dc = mt % PS;
      e_fd = (mt == 0);
      nb = 4'((m_disp >> (4 * di)) & 16'hF);
      e_seg = m_dv ? ref_seg[nb] : 7'h7F;
      sup = 0;
`ifdef SEG_SCAN_LZB_EN
      sup = (di != 0) && ((m_disp >> (4 * di)) == 16'h0);
`endif
      e_an = 4'hF;
      if (dc >= GD && m_dv && !blank && !sup) e_an[di] = 1'b0;
      if (mt == FRAME - 1 && m_pf) begin
        m_disp = m_pend; m_dv = 1; m_pf = 0;
      end else if (load_valid && !m_pf) begin
        m_pend = load_data; m_pf = 1; acc = 1;
      end
      mt = (mt + 1) % FRAME;
    end
    #1;
    chk("seg", 16'(seg), 16'(e_seg));
    chk("an", 16'(an), 16'(e_an));
    chk("frame_done", 16'(frame_done), 16'(e_fd));
    chk("load_ready", 16'(load_ready), 16'(!m_pf));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_word(input logic [15:0] w);
    bit ok = 0;
    load_valid = 1'b1;
    load_data  = w;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (acc) begin ok = 1; break; end
    end
    load_valid = 1'b0;
    bound_fail("load_accept", ok);
  endtask

  task automatic wait_pos(input int pos);
    bit ok = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (mt == pos) begin ok = 1; break; end
      tick();
    end
    bound_fail("wait_pos", ok);
  endtask

  initial begin
    // Reset held for 3 cycles, then idle for more than 2 frames.
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(2 * FRAME + 6);

    // Single load and visibility.
    load_word(16'h1234);
    run(2 * FRAME);

    // Back-to-back: second word held valid until accepted after the transfer.
    load_word(16'h1111);
    load_word(16'h2222);
    run(2 * FRAME + 4);

    // Leading zeros.
    load_word(16'h0050);
    run(2 * FRAME + 4);
    load_word(16'h0000);
    run(2 * FRAME + 4);

    // Randomized traffic with blank toggling.
    for (int i = 0; i < 400; i++) begin
      load_valid = ($urandom_range(3) == 0);
      load_data  = 16'($urandom);
      if ($urandom_range(15) == 0) blank = ~blank;
      tick();
    end
    load_valid = 1'b0;
    blank = 1'b0;
    run(2 * FRAME + 4);

    // Reset mid-frame at idx=2, cnt=5 with a word pending.
    wait_pos(2);
    load_word(16'hABCD);
    wait_pos(2 * PS + 5);
    bound_fail("pending_before_reset", m_pf);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run(2 * FRAME + 4);

    // Blank asserted mid-slot, then released.
    load_word(16'h9876);
    run(FRAME + 4);
    wait_pos(PS + 4);
    blank = 1'b1;
    run(2 * FRAME + 3);
    blank = 1'b0;
    run(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
